// File: rtl/float_to_fixed_param.sv
// ============================================================================
// Module     : float_to_fixed_param
// Description: Multi-cycle IEEE-754 float to signed Q(FW-FRAC).FRAC converter
//              with saturation and status flags. Macro F2FX_ROUND_NEAREST_EN
//              selects round-to-nearest-even; otherwise the result truncates.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module float_to_fixed_param #(
    parameter int EW   = 8,
    parameter int SW   = 23,
    parameter int FW   = 32,
    parameter int FRAC = 16
) (
    input  logic             CLK,
    input  logic             RST_FF,
    input  logic             Begin_FSM_FF,
    input  logic [EW+SW:0]   F,
    output logic             ACK_FF,
    output logic [FW-1:0]    RESULT,
    output logic             OVF_FLAG,
    output logic             INVALID_FLAG,
    output logic             INEXACT_FLAG
);

    localparam int          c_BIAS   = 2**(EW-1) - 1;
    localparam int          c_LW     = FW + SW + 1;
    localparam int          c_RW     = 2*SW + 3;
    localparam logic [FW:0] c_NEGLIM = (FW+1)'(1) << (FW-1);
    localparam logic [FW:0] c_POSLIM = c_NEGLIM - (FW+1)'(1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LOAD  = 3'd1;
    localparam logic [2:0] c_ALIGN = 3'd2;
    localparam logic [2:0] c_ROUND = 3'd3;
    localparam logic [2:0] c_PACK  = 3'd4;
    localparam logic [2:0] c_DONE  = 3'd5;

    logic [2:0]        r_state, w_next;
    logic              w_accept;
    logic [EW+SW:0]    r_f;
    logic              r_s, r_zero, r_nan, r_inf;
    logic [EW-1:0]     r_e;
    logic [SW-1:0]     r_m;
    logic [FW-1:0]     r_mag;
    logic              r_guard, r_sticky, r_aovf;
    logic [FW:0]       r_rmag;
    logic              r_inexact;
    logic [FW-1:0]     r_result;
    logic              r_ovf, r_invalid, r_inexact_out;

    logic [SW:0]       w_sig;
    logic signed [31:0] w_k;
    logic [31:0]       w_lsh, w_rsh;
    logic [c_LW-1:0]   w_wl;
    logic [c_RW-1:0]   w_wr;
    logic [FW-1:0]     w_rint;
    logic              w_rovf, w_up, w_ovf;

    always_ff @(posedge CLK or posedge RST_FF) begin
        if (RST_FF) r_state <= c_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (Begin_FSM_FF) w_next = c_LOAD;
            c_LOAD:  w_next = c_ALIGN;
            c_ALIGN: w_next = c_ROUND;
            c_ROUND: w_next = c_PACK;
            c_PACK:  w_next = c_DONE;
            c_DONE:  if (Begin_FSM_FF) w_next = c_LOAD;
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        ACK_FF   = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            c_IDLE:  w_accept = Begin_FSM_FF;
            c_DONE: begin
                ACK_FF   = 1'b1;
                w_accept = Begin_FSM_FF;
            end
            default: ;
        endcase
    end

    // Barrel alignment: left path keeps FW bits, right path keeps guard/sticky
    assign w_sig = {1'b1, r_m};
    assign w_k   = $signed(32'(r_e)) - c_BIAS + FRAC - SW;
    assign w_lsh = w_k;
    assign w_rsh = -w_k;
    assign w_wl  = {{(c_LW-SW-1){1'b0}}, w_sig} << w_lsh;
    assign w_wr  = {w_sig, {(SW+2){1'b0}}} >> w_rsh;

    generate
        if (SW + 1 > FW) begin : g_rnarrow
            assign w_rint = w_wr[SW+2 +: FW];
            assign w_rovf = |w_wr[c_RW-1:SW+2+FW];
        end else begin : g_rwide
            assign w_rint = FW'(w_wr[c_RW-1:SW+2]);
            assign w_rovf = 1'b0;
        end
    endgenerate

`ifdef F2FX_ROUND_NEAREST_EN
    assign w_up = r_guard & (r_sticky | r_mag[0]);
`else
    assign w_up = 1'b0;
`endif

    assign w_ovf = r_aovf | (r_s ? (r_rmag > c_NEGLIM) : (r_rmag > c_POSLIM));

    always_ff @(posedge CLK or posedge RST_FF) begin
        if (RST_FF) begin
            r_f           <= '0;
            r_s           <= 1'b0;
            r_e           <= '0;
            r_m           <= '0;
            r_zero        <= 1'b0;
            r_nan         <= 1'b0;
            r_inf         <= 1'b0;
            r_mag         <= '0;
            r_guard       <= 1'b0;
            r_sticky      <= 1'b0;
            r_aovf        <= 1'b0;
            r_rmag        <= '0;
            r_inexact     <= 1'b0;
            r_result      <= '0;
            r_ovf         <= 1'b0;
            r_invalid     <= 1'b0;
            r_inexact_out <= 1'b0;
        end else begin
            if (w_accept) begin
                r_f           <= F;
                r_ovf         <= 1'b0;
                r_invalid     <= 1'b0;
                r_inexact_out <= 1'b0;
            end
            case (r_state)
                c_LOAD: begin
                    r_s    <= r_f[EW+SW];
                    r_e    <= r_f[EW+SW-1:SW];
                    r_m    <= r_f[SW-1:0];
                    r_zero <= (r_f[EW+SW-1:SW] == '0);
                    r_nan  <= (&r_f[EW+SW-1:SW]) & (|r_f[SW-1:0]);
                    r_inf  <= (&r_f[EW+SW-1:SW]) & ~(|r_f[SW-1:0]);
                end
                c_ALIGN: begin
                    r_mag    <= '0;
                    r_guard  <= 1'b0;
                    r_sticky <= 1'b0;
                    r_aovf   <= 1'b0;
                    if (r_zero || r_nan) begin
                        r_aovf <= 1'b0;
                    end else if (r_inf) begin
                        r_aovf <= 1'b1;
                    end else if (w_k >= 0) begin
                        if (w_k >= FW) begin
                            r_aovf <= 1'b1;
                        end else begin
                            r_mag  <= w_wl[FW-1:0];
                            r_aovf <= |w_wl[c_LW-1:FW];
                        end
                    end else if (w_k < -(SW+2)) begin
                        r_sticky <= 1'b1;
                    end else begin
                        r_mag    <= w_rint;
                        r_aovf   <= w_rovf;
                        r_guard  <= w_wr[SW+1];
                        r_sticky <= |w_wr[SW:0];
                    end
                end
                c_ROUND: begin
                    r_rmag    <= {1'b0, r_mag} + {{FW{1'b0}}, w_up};
                    r_inexact <= r_guard | r_sticky;
                end
                c_PACK: begin
                    r_inexact_out <= r_inexact;
                    if (r_nan) begin
                        r_result  <= '0;
                        r_invalid <= 1'b1;
                        r_ovf     <= 1'b0;
                    end else if (w_ovf) begin
                        r_result  <= r_s ? c_NEGLIM[FW-1:0] : c_POSLIM[FW-1:0];
                        r_invalid <= 1'b0;
                        r_ovf     <= 1'b1;
                    end else begin
                        r_result  <= r_s ? -r_rmag[FW-1:0] : r_rmag[FW-1:0];
                        r_invalid <= 1'b0;
                        r_ovf     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign RESULT       = r_result;
    assign OVF_FLAG     = r_ovf;
    assign INVALID_FLAG = r_invalid;
    assign INEXACT_FLAG = r_inexact_out;

endmodule

`default_nettype wire

// File: tb/tb_float_to_fixed_param.sv
// ============================================================================
// Module     : tb_float_to_fixed_param
// Description: Directed self-checking bench for float_to_fixed_param (default
//              EW=8, SW=23, FW=32, FRAC=16).
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_float_to_fixed_param;

    logic        CLK = 1'b0;
    logic        RST_FF;
    logic        Begin_FSM_FF;
    logic [31:0] F;
    logic        ACK_FF;
    logic [31:0] RESULT;
    logic        OVF_FLAG;
    logic        INVALID_FLAG;
    logic        INEXACT_FLAG;

    int checks   = 0;
    int failures = 0;

    float_to_fixed_param #(.EW(8), .SW(23), .FW(32), .FRAC(16)) dut (
        .CLK          (CLK),
        .RST_FF       (RST_FF),
        .Begin_FSM_FF (Begin_FSM_FF),
        .F            (F),
        .ACK_FF       (ACK_FF),
        .RESULT       (RESULT),
        .OVF_FLAG     (OVF_FLAG),
        .INVALID_FLAG (INVALID_FLAG),
        .INEXACT_FLAG (INEXACT_FLAG)
    );

    always #5 CLK = ~CLK;

    // Leaves the bench at the falling edge after the start-sampling edge.
    task automatic start_conv(input logic [31:0] f);
        @(negedge CLK);
        F            = f;
        Begin_FSM_FF = 1'b1;
        @(negedge CLK);
        Begin_FSM_FF = 1'b0;
        F            = 32'hDEADBEEF;
    endtask

    // n counts rising edges since (and including) the start-sampling edge.
    task automatic wait_ack(inout int n);
        while (ACK_FF !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
    endtask

    task automatic check_conv(input string name, input logic [31:0] f,
                              input logic [31:0] er, input logic eo,
                              input logic ei, input logic ex);
        int n;
        start_conv(f);
        n = 1;
        wait_ack(n);
        checks++;
        if (n !== 5) begin
            failures++;
            $display("FAIL %s latency got=%0d exp=5", name, n);
        end
        checks++;
        if (RESULT !== er) begin
            failures++;
            $display("FAIL %s result got=%h exp=%h", name, RESULT, er);
        end
        checks++;
        if ({OVF_FLAG, INVALID_FLAG, INEXACT_FLAG} !== {eo, ei, ex}) begin
            failures++;
            $display("FAIL %s flags(ovf,inv,inx) got=%b%b%b exp=%b%b%b",
                     name, OVF_FLAG, INVALID_FLAG, INEXACT_FLAG, eo, ei, ex);
        end
    endtask

    task automatic test_reset;
        RST_FF       = 1'b1;
        Begin_FSM_FF = 1'b0;
        F            = 32'h0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({ACK_FF, RESULT, OVF_FLAG, INVALID_FLAG, INEXACT_FLAG} !== 36'h0) begin
            failures++;
            $display("FAIL reset ack=%b result=%h flags=%b%b%b exp all 0",
                     ACK_FF, RESULT, OVF_FLAG, INVALID_FLAG, INEXACT_FLAG);
        end
        RST_FF = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (ACK_FF !== 1'b0) begin
            failures++;
            $display("FAIL idle_ack got=%b exp=0", ACK_FF);
        end
    endtask

    task automatic test_basic;
        check_conv("one_p15",   32'h3F933333, 32'h00012666, 1'b0, 1'b0, 1'b1);
        check_conv("one",       32'h3F800000, 32'h00010000, 1'b0, 1'b0, 1'b0);
        check_conv("neg15_25",  32'hC1740000, 32'hFFF0C000, 1'b0, 1'b0, 1'b0);
        check_conv("max_pos",   32'h46FFFFFE, 32'h7FFFFF00, 1'b0, 1'b0, 1'b0);
        check_conv("neg_zero",  32'h80000000, 32'h00000000, 1'b0, 1'b0, 1'b0);
        check_conv("tiny",      32'h00800000, 32'h00000000, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_saturation;
        check_conv("neg32768",  32'hC7000000, 32'h80000000, 1'b0, 1'b0, 1'b0);
        check_conv("neg32768p", 32'hC7000080, 32'h80000000, 1'b1, 1'b0, 1'b0);
        check_conv("pos40000",  32'h471C4000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_special;
        check_conv("pos_inf",   32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0);
        check_conv("neg_inf",   32'hFF800000, 32'h80000000, 1'b1, 1'b0, 1'b0);
        check_conv("nan",       32'h7FC00000, 32'h00000000, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_rounding;
`ifdef F2FX_ROUND_NEAREST_EN
        check_conv("p1_5lsb",   32'h37C00000, 32'h00000002, 1'b0, 1'b0, 1'b1);
        check_conv("n1_5lsb",   32'hB7C00000, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1);
`else
        check_conv("p1_5lsb",   32'h37C00000, 32'h00000001, 1'b0, 1'b0, 1'b1);
        check_conv("n1_5lsb",   32'hB7C00000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
`endif
        check_conv("p2_5lsb",   32'h38200000, 32'h00000002, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_begin_ignored;
        int n;
        start_conv(32'h3F933333);
        @(negedge CLK);
        Begin_FSM_FF = 1'b1;
        F            = 32'h3F800000;
        @(negedge CLK);
        Begin_FSM_FF = 1'b0;
        n = 3;
        wait_ack(n);
        checks++;
        if (n !== 5 || RESULT !== 32'h00012666) begin
            failures++;
            $display("FAIL begin_ignored latency=%0d result=%h exp 5 / 00012666", n, RESULT);
        end
        @(negedge CLK);
        checks++;
        if (ACK_FF !== 1'b1 || RESULT !== 32'h00012666) begin
            failures++;
            $display("FAIL done_hold ack=%b result=%h exp 1 / 00012666", ACK_FF, RESULT);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        check_conv("b2b_first", 32'h471C4000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0);
        Begin_FSM_FF = 1'b1;
        F            = 32'hC1740000;
        @(negedge CLK);
        Begin_FSM_FF = 1'b0;
        F            = 32'hDEADBEEF;
        checks++;
        if (ACK_FF !== 1'b0 || OVF_FLAG !== 1'b0) begin
            failures++;
            $display("FAIL b2b_restart ack=%b ovf=%b exp 0 / 0", ACK_FF, OVF_FLAG);
        end
        n = 1;
        wait_ack(n);
        checks++;
        if (n !== 5 || RESULT !== 32'hFFF0C000 || OVF_FLAG !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second latency=%0d result=%h ovf=%b exp 5 / FFF0C000 / 0",
                     n, RESULT, OVF_FLAG);
        end
    endtask

    task automatic test_reset_mid;
        check_conv("pre_reset", 32'h471C4000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0);
        start_conv(32'h3F800000);
        repeat (2) @(negedge CLK);
        RST_FF = 1'b1;
        #1;
        checks++;
        if ({ACK_FF, RESULT, OVF_FLAG, INVALID_FLAG, INEXACT_FLAG} !== 36'h0) begin
            failures++;
            $display("FAIL mid_reset ack=%b result=%h flags=%b%b%b exp all 0",
                     ACK_FF, RESULT, OVF_FLAG, INVALID_FLAG, INEXACT_FLAG);
        end
        @(negedge CLK);
        RST_FF = 1'b0;
        check_conv("post_reset", 32'h3F800000, 32'h00010000, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_special();
        test_rounding();
        test_begin_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
